// File: rtl/scan_sequencer_pkg.sv
// Shared state enumeration and decoder-enable constants for the scan sequencer.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] ENA_ON  = 2'b10;
  localparam logic [1:0] ENA_OFF = 2'b00;

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan sequencer and whoever drives it.
interface scan_sequencer_if;

  logic       iStart;
  logic       iStop;
  logic       iHold;
  logic [2:0] iLast;
  logic [2:0] oData;
  logic [1:0] oEna;
  logic       oWrap;
  logic       oBusy;

  modport master (
    output iStart, iStop, iHold, iLast,
    input  oData, oEna, oWrap, oBusy
  );

  modport slave (
    input  iStart, iStop, iHold, iLast,
    output oData, oEna, oWrap, oBusy
  );

endinterface

// File: rtl/scan_prescaler.sv
// Step prescaler: counts 0..DIV-1 and flags the last count as the step tick.
// With SCAN_BLANK_EN defined it also predicts whether the next cycle is a tick.
module scan_prescaler #(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic tick,
  output logic blankNext
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!hold) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST_CNT);

`ifdef SCAN_BLANK_EN
  // Lets the owner register its enable one cycle ahead so the blank lines up with the tick.
  assign blankNext = !rst && !clear && (hold ? tick : (count + CNT_W'(1) == LAST_CNT));
`else
  assign blankNext = 1'b0;
`endif

endmodule

// File: rtl/scan_sequencer.sv
// Display digit scan sequencer: steps a 3-bit select index 0..last every DIV clocks.
// Define SCAN_BLANK_EN to blank the decoder during each step-tick cycle.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  scan_sequencer_if.slave  bus
);

  state_t     state;
  state_t     stateNext;
  logic [2:0] lastQ;
  logic [2:0] data;
  logic [1:0] ena;
  logic       wrap;
  logic       busy;

  logic       tick;
  logic       blankNext;
  logic       step;
  logic       preClear;
  logic       preHold;

  scan_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) uPrescaler (
    .clk       (clk),
    .rst       (rst),
    .clear     (preClear),
    .hold      (preHold),
    .tick      (tick),
    .blankNext (blankNext)
  );

  // Stop beats hold, and a start that coincides with stop is treated as no start.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (bus.iStart && !bus.iStop) stateNext = SCAN;
      SCAN: begin
        if (bus.iStop)      stateNext = IDLE;
        else if (bus.iHold) stateNext = HOLD;
      end
      HOLD: begin
        if (bus.iStop)       stateNext = IDLE;
        else if (!bus.iHold) stateNext = SCAN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A hold request freezes the prescaler and index at the very edge it is sampled.
  assign step     = (state == SCAN) && tick && !bus.iStop && !bus.iHold;
  assign preClear = (state == IDLE) || (stateNext == IDLE);
  assign preHold  = (state == HOLD) || bus.iHold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lastQ <= '0;
      data  <= '0;
      ena   <= ENA_OFF;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext != IDLE);
      wrap  <= step && (data == lastQ);

      if (state == IDLE && stateNext == SCAN) begin
        lastQ <= bus.iLast;
      end

      if (stateNext == IDLE) begin
        data <= '0;
      end else if (step) begin
        data <= (data == lastQ) ? 3'd0 : data + 3'd1;
      end

      if (stateNext == IDLE) begin
        ena <= ENA_OFF;
      end else if (stateNext == SCAN && blankNext) begin
        ena <= ENA_OFF;
      end else begin
        ena <= ENA_ON;
      end
    end
  end

  assign bus.oData = data;
  assign bus.oEna  = ena;
  assign bus.oWrap = wrap;
  assign bus.oBusy = busy;

endmodule
